timer_multi_ch: RTL and testbench

Parametrised multi-channel up-counting timer; each channel runs in one-shot or periodic mode against its own terminal count. Channels support retrigger, abort and a registered expiry pulse, with an optional shared prescaler. The block sits in the timer subsystem beside the single-channel one-shot timer and feeds interrupt/event logic through `expire`.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_channel.sv | 57 +++++
 rtl/timer_multi_ch.sv | 66 ++++++
 tb/tb_timer_multi_ch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer subsystem: mode encodings and default widths.
package timer_pkg;

  typedef enum logic {
    TIMER_MODE_ONESHOT  = 1'b0,
    TIMER_MODE_PERIODIC = 1'b1
  } timer_mode_e;

  localparam int unsigned TIMER_DEFAULT_N_CH    = 4;
  localparam int unsigned TIMER_DEFAULT_CNT_W   = 32;
  localparam int unsigned TIMER_DEFAULT_PRESC_W = 16;

endpackage

// File: rtl/timer_channel.sv
// Single up-counting timer channel: stop > trig > expiry > increment, registered expiry pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = TIMER_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             stop,
  input  logic             tick,
  input  logic             mode,
  input  logic [CNT_W-1:0] cfg_max,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             expire_d, expire_q;
  logic             running;
  logic             at_max;

  assign running = (cnt_q != '0);
  // Saturating compare keeps the counter from ever wrapping when cfg_max drops below it.
  assign at_max  = (cnt_q >= cfg_max);

  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (stop) begin
      cnt_d = '0;
    end else if (trig) begin
      cnt_d = CNT_W'(1);
    end else if (tick && running && at_max) begin
      expire_d = 1'b1;
      cnt_d    = (mode == TIMER_MODE_PERIODIC) ? CNT_W'(1) : '0;
    end else if (tick && running) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign cnt    = cnt_q;
  assign busy   = running;
  assign expire = expire_q;

endmodule

// File: rtl/timer_multi_ch.sv
// Multi-channel timer top: shared tick source and per-channel bus slicing.
// Define TIMER_PRESCALE_EN to add the shared prescaler and the presc_div port.
module timer_multi_ch
  import timer_pkg::*;
#(
  parameter int unsigned N_CH    = TIMER_DEFAULT_N_CH,
  parameter int unsigned CNT_W   = TIMER_DEFAULT_CNT_W,
  parameter int unsigned PRESC_W = TIMER_DEFAULT_PRESC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       trig,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH*CNT_W-1:0] cfg_max,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESC_W-1:0]    presc_div,
`endif
  output logic [N_CH*CNT_W-1:0] cnt,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       expire
);

  logic tick;

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_d, presc_q;

  // Free-running; >= recovers cleanly if presc_div is lowered below the current count.
  always_comb begin
    presc_d = (presc_q >= presc_div) ? '0 : presc_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = (presc_q == presc_div);
`else
  logic [PRESC_W-1:0] presc_unused;
  assign presc_unused = '0;
  assign tick         = 1'b1;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .trig    (trig[i]),
      .stop    (stop[i]),
      .tick    (tick),
      .mode    (mode[i]),
      .cfg_max (cfg_max[i*CNT_W +: CNT_W]),
      .cnt     (cnt[i*CNT_W +: CNT_W]),
      .busy    (busy[i]),
      .expire  (expire[i])
    );
  end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Self-checking bench for timer_multi_ch: vector table through a scoreboard plus corner sequences.
module tb_timer_multi_ch;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int PW = 16;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   trig  = '0;
  logic [N-1:0]   stop  = '0;
  logic [N-1:0]   mode  = '0;
  logic [N*W-1:0] cfg_max = '0;
  logic [N*W-1:0] cnt;
  logic [N-1:0]   busy;
  logic [N-1:0]   expire;
`ifdef TIMER_PRESCALE_EN
  logic [PW-1:0]  presc_div = '0;
`endif

  timer_multi_ch #(
    .N_CH    (N),
    .CNT_W   (W),
    .PRESC_W (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .stop      (stop),
    .mode      (mode),
    .cfg_max   (cfg_max),
`ifdef TIMER_PRESCALE_EN
    .presc_div (presc_div),
`endif
    .cnt       (cnt),
    .busy      (busy),
    .expire    (expire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   trig;
    logic [N-1:0]   stop;
    logic [N-1:0]   mode;
    logic [N*W-1:0] cfg;
    logic [N*W-1:0] ecnt;
    logic [N-1:0]   eexp;
  } vec_t;

  typedef struct {
    logic [N*W-1:0] ecnt;
    logic [N-1:0]   eexp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [N-1:0] busy_of(input logic [N*W-1:0] c);
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = (c[i*W +: W] != '0);
    return b;
  endfunction

  // Channel 0 only; other channels idle with an arbitrary terminal count.
  function automatic vec_t v1(input logic t, input logic s, input logic m, input int unsigned c,
                              input int unsigned ec, input logic ee);
    vec_t v;
    v.trig = {3'b000, t};
    v.stop = {3'b000, s};
    v.mode = {3'b000, m};
    v.cfg  = {32'd9, 32'd9, 32'd9, c};
    v.ecnt = {32'd0, 32'd0, 32'd0, ec};
    v.eexp = {3'b000, ee};
    return v;
  endfunction

  function automatic vec_t vm(input logic [N-1:0] t, input logic [N*W-1:0] ec,
                              input logic [N-1:0] ee);
    vec_t v;
    v.trig = t;
    v.stop = '0;
    v.mode = '0;
    v.cfg  = {32'd7, 32'd4, 32'd4, 32'd2};
    v.ecnt = ec;
    v.eexp = ee;
    return v;
  endfunction

  initial begin
    int   n;
    exp_t e;

    // One-shot, cfg_max 5.
    vecs.push_back(v1(1, 0, 0, 5, 1, 0));
    vecs.push_back(v1(0, 0, 0, 5, 2, 0));
    vecs.push_back(v1(0, 0, 0, 5, 3, 0));
    vecs.push_back(v1(0, 0, 0, 5, 4, 0));
    vecs.push_back(v1(0, 0, 0, 5, 5, 0));
    vecs.push_back(v1(0, 0, 0, 5, 0, 1));
    vecs.push_back(v1(0, 0, 0, 5, 0, 0));
    // Periodic, cfg_max 3, then stop.
    vecs.push_back(v1(1, 0, 1, 3, 1, 0));
    vecs.push_back(v1(0, 0, 1, 3, 2, 0));
    vecs.push_back(v1(0, 0, 1, 3, 3, 0));
    vecs.push_back(v1(0, 0, 1, 3, 1, 1));
    vecs.push_back(v1(0, 0, 1, 3, 2, 0));
    vecs.push_back(v1(0, 0, 1, 3, 3, 0));
    vecs.push_back(v1(0, 0, 1, 3, 1, 1));
    vecs.push_back(v1(0, 0, 1, 3, 2, 0));
    vecs.push_back(v1(0, 1, 1, 3, 0, 0));
    vecs.push_back(v1(0, 0, 1, 3, 0, 0));
    // Retrigger at terminal count wins over expiry; stop wins over trig.
    vecs.push_back(v1(1, 0, 0, 3, 1, 0));
    vecs.push_back(v1(0, 0, 0, 3, 2, 0));
    vecs.push_back(v1(0, 0, 0, 3, 3, 0));
    vecs.push_back(v1(1, 0, 0, 3, 1, 0));
    vecs.push_back(v1(1, 1, 0, 3, 0, 0));
    vecs.push_back(v1(0, 0, 0, 3, 0, 0));
    // cfg_max 0 expires on first tick.
    vecs.push_back(v1(1, 0, 0, 0, 1, 0));
    vecs.push_back(v1(0, 0, 0, 0, 0, 1));
    vecs.push_back(v1(0, 0, 0, 0, 0, 0));
    // Lower cfg_max from 10 to 2 while cnt is 6.
    vecs.push_back(v1(1, 0, 0, 10, 1, 0));
    vecs.push_back(v1(0, 0, 0, 10, 2, 0));
    vecs.push_back(v1(0, 0, 0, 10, 3, 0));
    vecs.push_back(v1(0, 0, 0, 10, 4, 0));
    vecs.push_back(v1(0, 0, 0, 10, 5, 0));
    vecs.push_back(v1(0, 0, 0, 10, 6, 0));
    vecs.push_back(v1(0, 0, 0, 2, 0, 1));
    vecs.push_back(v1(0, 0, 0, 2, 0, 0));
    // Four channels, cfg_max 2/4/4/7, triggered together.
    vecs.push_back(vm(4'hf, {32'd1, 32'd1, 32'd1, 32'd1}, 4'b0000));
    vecs.push_back(vm(4'h0, {32'd2, 32'd2, 32'd2, 32'd2}, 4'b0000));
    vecs.push_back(vm(4'h0, {32'd3, 32'd3, 32'd3, 32'd0}, 4'b0001));
    vecs.push_back(vm(4'h0, {32'd4, 32'd4, 32'd4, 32'd0}, 4'b0000));
    vecs.push_back(vm(4'h0, {32'd5, 32'd0, 32'd0, 32'd0}, 4'b0110));
    vecs.push_back(vm(4'h0, {32'd6, 32'd0, 32'd0, 32'd0}, 4'b0000));
    vecs.push_back(vm(4'h0, {32'd7, 32'd0, 32'd0, 32'd0}, 4'b0000));
    vecs.push_back(vm(4'h0, {32'd0, 32'd0, 32'd0, 32'd0}, 4'b1000));
    vecs.push_back(vm(4'h0, {32'd0, 32'd0, 32'd0, 32'd0}, 4'b0000));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset cnt", cnt, '0);
    check("reset busy", busy, '0);
    check("reset expire", expire, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle cnt", cnt, '0);

    foreach (vecs[i]) begin
      trig    = vecs[i].trig;
      stop    = vecs[i].stop;
      mode    = vecs[i].mode;
      cfg_max = vecs[i].cfg;
      sb.push_back('{ecnt: vecs[i].ecnt, eexp: vecs[i].eexp});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d cnt", i), cnt, e.ecnt);
      check($sformatf("v%0d expire", i), expire, e.eexp);
      check($sformatf("v%0d busy", i), busy, busy_of(e.ecnt));
    end

    // Periodic period measurement, cfg_max 4.
    trig    = 4'b0001;
    mode    = 4'b0001;
    cfg_max = {32'd9, 32'd9, 32'd9, 32'd4};
    @(posedge clk);
    #1;
    trig = '0;
    n = 0;
    while (expire[0] !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first expire seen", 128'(n < 20), 128'(1));
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (expire[0] !== 1'b1 && n < 20);
    check("periodic period", 128'(n), 128'(4));

    // Asynchronous reset while an expiry pulse is high.
    check("pulse before reset", 128'(expire[0]), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst cnt", cnt, '0);
    check("async rst expire", expire, '0);
    check("async rst busy", busy, '0);
    mode    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post rst idle", cnt, '0);

`ifdef TIMER_PRESCALE_EN
    // Prescaler divide by 3, cfg_max 2.
    presc_div = 16'd2;
    trig      = 4'b0001;
    cfg_max   = {32'd9, 32'd9, 32'd9, 32'd2};
    @(posedge clk);
    #1;
    trig = '0;
    check("presc trig immediate", cnt[W-1:0], 1);
    n = 0;
    while (cnt[W-1:0] !== 32'd2 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("presc first step bound", 128'(n <= 3), 128'(1));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("presc hold %0d", k), cnt[W-1:0], 2);
      check($sformatf("presc no expire %0d", k), expire, '0);
    end
    @(posedge clk);
    #1;
    check("presc expire", expire, 4'b0001);
    check("presc cnt cleared", cnt, '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
